// File: rtl/snek_dir_ctrl_if.sv
// Button/frame/run inputs and direction outputs of the snake direction controller.
interface snek_dir_ctrl_if;
  logic [3:0] buttons;
  logic       frame_clk;
  logic       run;
  logic [1:0] dir;
  logic       dir_changed;
  logic [3:0] btn_level;

  modport master (
    output buttons, frame_clk, run,
    input  dir, dir_changed, btn_level
  );

  modport slave (
    input  buttons, frame_clk, run,
    output dir, dir_changed, btn_level
  );
endinterface

// File: rtl/snek_dir_ctrl.sv
// Snake direction controller: button sync/debounce/press detect, reversal filter, frame-aligned commit.
// Define SNEK_DIR_CTRL_TURN_QUEUE_EN to replace the single pending slot with a 2-entry turn FIFO.
module snek_dir_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned CTR_W           = 18
) (
  input  logic            clk,
  input  logic            rst,
  snek_dir_ctrl_if.slave  bus
);

  localparam logic [CTR_W-1:0] CNT_LAST = CTR_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       btn_s1, btn_s2, lvl, lvl_d;
  logic [CTR_W-1:0] cnt [4];
  logic             fc_s1, fc_s2, fc_d;
  logic [1:0]       dir_q, dir_n;
  logic             chg_q;

  logic [3:0] press;
  logic       req_v, fe, accept;
  logic [1:0] req, tail;

  // Input synchronisers, per-bit debounce and frame_clk edge history
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_s1 <= '0;
      btn_s2 <= '0;
      lvl    <= '0;
      lvl_d  <= '0;
      fc_s1  <= 1'b0;
      fc_s2  <= 1'b0;
      fc_d   <= 1'b0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      btn_s1 <= bus.buttons;
      btn_s2 <= btn_s1;
      lvl_d  <= lvl;
      fc_s1  <= bus.frame_clk;
      fc_s2  <= fc_s1;
      fc_d   <= fc_s2;
      for (int i = 0; i < 4; i++) begin
        if (btn_s2[i] == lvl[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          cnt[i] <= '0;
          lvl[i] <= ~lvl[i];
        end else begin
          cnt[i] <= cnt[i] + CTR_W'(1);
        end
      end
    end
  end

  assign press = lvl & ~lvl_d;
  assign fe    = fc_s2 & ~fc_d;

  // Simultaneous presses resolve left > right > up > down
  always_comb begin
    req   = 2'd0;
    req_v = |press;
    if      (press[1]) req = 2'd0;
    else if (press[0]) req = 2'd1;
    else if (press[2]) req = 2'd2;
    else if (press[3]) req = 2'd3;
  end

  assign accept = req_v && (req != tail) && (req != (tail ^ 2'b01));

`ifdef SNEK_DIR_CTRL_TURN_QUEUE_EN
  logic [1:0] q0, q1, q0_n, q1_n, q_cnt, q_cnt_n, fill;
  logic       pop;

  assign tail = (q_cnt == 2'd2) ? q1 : (q_cnt == 2'd1) ? q0 : dir_q;
  assign pop  = fe && (q_cnt != 2'd0);

  always_comb begin
    dir_n   = dir_q;
    q0_n    = q0;
    q1_n    = q1;
    q_cnt_n = q_cnt;
    fill    = q_cnt - 2'(pop);
    if (!bus.run) begin
      q_cnt_n = 2'd0;
      if (req_v) dir_n = req;
    end else begin
      if (pop) begin
        dir_n = q0;
        q0_n  = q1;
      end
      // Push lands behind whatever survives this cycle's pop
      if (accept && fill != 2'd2) begin
        if (fill == 2'd0) q0_n = req;
        else              q1_n = req;
        fill = fill + 2'd1;
      end
      q_cnt_n = fill;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q0    <= 2'd0;
      q1    <= 2'd0;
      q_cnt <= 2'd0;
    end else begin
      q0    <= q0_n;
      q1    <= q1_n;
      q_cnt <= q_cnt_n;
    end
  end
`else
  logic [1:0] pend, pend_n;
  logic       pend_v, pend_v_n;

  assign tail = pend_v ? pend : dir_q;

  always_comb begin
    dir_n    = dir_q;
    pend_n   = pend;
    pend_v_n = pend_v;
    if (!bus.run) begin
      pend_v_n = 1'b0;
      if (req_v) dir_n = req;
    end else begin
      if (fe && pend_v) begin
        dir_n    = pend;
        pend_v_n = 1'b0;
      end
      // A coincident request was checked against the old tail and lands for the next frame
      if (accept) begin
        pend_n   = req;
        pend_v_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend   <= 2'd0;
      pend_v <= 1'b0;
    end else begin
      pend   <= pend_n;
      pend_v <= pend_v_n;
    end
  end
`endif

  // Registered direction and change pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dir_q <= 2'd0;
      chg_q <= 1'b0;
    end else begin
      dir_q <= dir_n;
      chg_q <= (dir_n != dir_q);
    end
  end

  assign bus.dir         = dir_q;
  assign bus.dir_changed = chg_q;
  assign bus.btn_level   = lvl;

endmodule

// File: doc/snek_dir_ctrl.md
Name: snek_dir_ctrl

Overview:
- Upstream input stage for the snake game top level. Conditions the four raw push-buttons: synchronises, debounces and detects press edges.
- Turns accepted presses into a 2-bit direction that the snake generator consumes.
- Direction changes are committed only on frame-tick boundaries, and 180° reversals are rejected while the game runs.

Parameters:
- DEBOUNCE_CYCLES, 250000, consecutive clk cycles a raw button must hold a new level before the debounced level follows (10 ms at 25 MHz).
- CTR_W, 18, debounce counter width; must satisfy 2^CTR_W > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system pixel clock.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- buttons  in  4  raw asynchronous buttons, active-high: [0] right, [1] left, [2] up, [3] down.
- frame_clk  in  1  divided frame clock (level, synchronous to clk); its rising edge is the commit point.
- run  in  1  1 = game playing, 0 = splash/idle.
- dir  out  2  committed direction: 0 left, 1 right, 2 up, 3 down.
- dir_changed  out  1  one-cycle pulse when dir takes a new value.
- btn_level  out  4  debounced button levels, same bit order as buttons.

Behaviour:
- Reset (rst=0, asynchronous) clears all state:
  - outputs: dir=0, dir_changed=0, btn_level=0;
  - internals: synchronisers, counters, pending slot/queue and frame_clk edge register.
- Synchroniser: each buttons bit passes through 2 flops, sync[i].
- Debounce, per bit:
  - If sync[i]==btn_level[i], counter resets to 0.
  - Otherwise counter increments.
  - When counter reaches DEBOUNCE_CYCLES-1 while still differing, btn_level[i] toggles on the next edge and the counter clears.
  - Latency from a stable raw change to btn_level: 2 + DEBOUNCE_CYCLES cycles.
  - Counter never wraps: it saturates at the reload point.
- Press detect: press[i] = btn_level[i] & ~btn_level_d[i], a one-cycle pulse.
- Request mapping:
  - Simultaneous presses are resolved by priority left > right > up > down.
  - Request codes: left→0, right→1, up→2, down→3.
- Reference for checks: "tail" = the last pending entry if one exists, otherwise dir.
- Reversal rule, run=1:
  - A request equal to tail^1 (left↔right, up↔down) is dropped.
  - A request equal to tail is dropped (no-op).
- run=0:
  - No reversal check.
  - An accepted request writes dir directly on the next edge, pulses dir_changed if the value differs, and clears pending.
- Pending slot (default build):
  - One register plus a valid bit.
  - A new accepted request overwrites it.
- Commit point:
  - fe = frame_clk_sync & ~frame_clk_d, where frame_clk passes through a 2-flop sync and one delay flop.
  - On fe with pending valid, dir <= pending and the valid bit clears.
  - dir_changed pulses in the same cycle that dir updates.
  - Requests accepted from the same cycle as fe onward apply at the next fe.
  - If an accepted request and fe coincide, the commit uses the old pending content; the new request is evaluated against the old tail and then stored.
- run falling mid-game: pending is discarded on the 1→0 transition; dir holds its value.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: SNEK_DIR_CTRL_TURN_QUEUE_EN.
- Defined: pending becomes a 2-entry FIFO.
  - Accepted requests are pushed; tail = newest entry.
  - Each fe pops one entry into dir.
  - A push while full is dropped.
  - A simultaneous pop and push in the same cycle are both performed.
  - This lets a quick up-then-left sequence from "right" yield two turns on consecutive frames.
- Undefined: single overwrite slot as described in Behaviour; no FIFO logic is synthesised.

Test Plan (DEBOUNCE_CYCLES=4, CTR_W=3, frame_clk period 40 clk):
- Reset: hold rst=0 with buttons=4'hF → dir=0, dir_changed=0, btn_level=0. Release rst → btn_level=4'hF after 6 cycles.
- Bounce: toggle buttons[0] every 2 cycles for 20 cycles, then hold it high → btn_level[0] stays 0 during the toggling and rises exactly 6 cycles after the hold begins.
- Turn commit: run=1, dir=0, press up → dir stays 0 until the next frame_clk rising edge, then dir=2 with a 1-cycle dir_changed pulse.
- Reversal: run=1, dir=1, press left → dir remains 1 across 3 frames, dir_changed never asserts. Then press down → dir=3 at the next fe.
- Splash: run=0, dir=0, press right → dir=1 within 2 cycles of the press pulse, no fe needed.
- Double turn: run=1, dir=1, press up then left within one frame.
  - Default build: dir=0 at the next fe, one pulse.
  - With TURN_QUEUE_EN: dir=2 at fe1, then dir=0 at fe2.
